// File: rtl/scan_loader.sv
// Serial scan-chain master: streams whole pattern buffers out on sin while
// capturing the old buffer contents from sout as a readback byte stream.
//
// state | meaning
// IDLE  | waiting for start; scan interface parked (ssel=0, sclk=0, sin=0)
// LOAD  | wr_ready high, sclk held low, waiting for the next write byte
// SHIFT | clocking one byte out MSB-first, sampling sout before each sclk rise
// FIN   | ssel/busy dropped, done pulse, back to IDLE
module scan_loader #(
    parameter int buffer_size  = 22,
    parameter int buffer_width = 8,
    parameter int clk_div      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2:0]              addr,
    output logic                    busy,
    output logic                    done,
    input  logic [buffer_width-1:0] wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [buffer_width-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    sclk,
    output logic                    sin,
    input  logic                    sout,
    output logic                    ssel,
    output logic [2:0]              saddr
);

    localparam int PH_W   = $clog2(2 * clk_div);
    localparam int BIT_W  = $clog2(buffer_width + 1);
    localparam int BYTE_W = $clog2(buffer_size + 1);

    localparam logic [PH_W-1:0]   PH_SAMPLE = PH_W'(clk_div - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * clk_div - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(buffer_width - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(buffer_size - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

    state_t                  state;
    logic [PH_W-1:0]         ph;
    logic [BIT_W-1:0]        bit_cnt;
    logic [BYTE_W-1:0]       byte_cnt;
    logic [buffer_width-1:0] shreg;
    logic [buffer_width-1:0] cap;

    // shreg is cleared whenever SHIFT ends, so sin idles low outside SHIFT
    assign sin = shreg[buffer_width-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ph       <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            cap      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_ready <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            sclk     <= 1'b0;
            ssel     <= 1'b0;
            saddr    <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        saddr    <= addr;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        ssel     <= 1'b1;
                        wr_ready <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (wr_valid) begin
                        shreg    <= wr_data;
                        bit_cnt  <= '0;
                        ph       <= '0;
                        wr_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // last low-phase cycle: capture sout, then sclk rises
                    if (ph == PH_SAMPLE) begin
                        cap  <= {cap[buffer_width-2:0], sout};
                        sclk <= 1'b1;
                    end
                    if (ph == PH_LAST) begin
                        ph   <= '0;
                        sclk <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            shreg    <= '0;
                            rd_data  <= cap;
                            rd_valid <= 1'b1;
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt == BYTE_LAST) begin
                                ssel  <= 1'b0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= FIN;
                            end else begin
                                wr_ready <= 1'b1;
                                state    <= LOAD;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= {shreg[buffer_width-2:0], 1'b0};
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader: a bit-queue model of the eight pattern buffers sits on
// the scan interface; transfers are checked for contents, readback and timing.
module tb_scan_loader;
    localparam int BS = 22;
    localparam int BW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       sout = 1'b0;
    logic       use1 = 1'b0;

    logic       busy0, done0, wr_ready0, rd_valid0, sclk0, sin0, ssel0;
    logic       busy1, done1, wr_ready1, rd_valid1, sclk1, sin1, ssel1;
    logic [7:0] rd_data0, rd_data1;
    logic [2:0] saddr0, saddr1;

    wire logic       start0     = start & ~use1;
    wire logic       start1     = start & use1;
    wire logic       busy_m     = use1 ? busy1 : busy0;
    wire logic       done_m     = use1 ? done1 : done0;
    wire logic       wr_ready_m = use1 ? wr_ready1 : wr_ready0;
    wire logic       rd_valid_m = use1 ? rd_valid1 : rd_valid0;
    wire logic       sclk_m     = use1 ? sclk1 : sclk0;
    wire logic       sin_m      = use1 ? sin1 : sin0;
    wire logic       ssel_m     = use1 ? ssel1 : ssel0;
    wire logic [7:0] rd_data_m  = use1 ? rd_data1 : rd_data0;
    wire logic [2:0] saddr_m    = use1 ? saddr1 : saddr0;

    scan_loader #(.buffer_size(BS), .buffer_width(BW), .clk_div(2)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .addr(addr), .busy(busy0), .done(done0),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .sclk(sclk0), .sin(sin0),
        .sout(sout), .ssel(ssel0), .saddr(saddr0)
    );

    scan_loader #(.buffer_size(BS), .buffer_width(BW), .clk_div(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .addr(addr), .busy(busy1), .done(done1),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .sclk(sclk1), .sin(sin1),
        .sout(sout), .ssel(ssel1), .saddr(saddr1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // buffer model: each buffer is a chain of BS*BW bits, head drives sout
    bit         chain [8][$];
    logic [7:0] wbytes [BS];
    logic [7:0] exp_rd [$];
    logic [7:0] rdq [$];
    bit         sinq [$];

    logic [2:0] exp_addr = '0;
    int  per_exp = 4;
    int  rises, last_rise, per_bad, sel_bad, load_bad, stall_bad, done_cnt, done_cyc;
    bit  prev_sclk = 1'b0;
    bit  stalling = 1'b0;
    int  t_start;
    bit  timed_out, aborted;
    logic post_ssel, post_sclk, post_busy;

    always @(posedge clk) begin
        #1;
        if (sclk_m && !prev_sclk) begin
            rises++;
            if (((rises - 1) % BW) != 0 && (cyc - last_rise) != per_exp) per_bad++;
            last_rise = cyc;
            sinq.push_back(sin_m);
            if (ssel_m) begin
                chain[saddr_m].push_back(sin_m);
                void'(chain[saddr_m].pop_front());
            end
        end
        prev_sclk = sclk_m;
        if (rd_valid_m) rdq.push_back(rd_data_m);
        if (done_m) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_m && (!ssel_m || saddr_m != exp_addr)) sel_bad++;
        if (wr_ready_m && (sclk_m || sin_m)) load_bad++;
        if (stalling && (sclk_m || !ssel_m)) stall_bad++;
        sout = (ssel_m && chain[saddr_m].size() > 0) ? chain[saddr_m][0] : 1'b0;
    end

    function automatic logic [7:0] chain_byte(input int b, input int j);
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < BW; k++) v = {v[6:0], chain[b][j*BW+k]};
        return v;
    endfunction

    task automatic run_xfer(input bit u1, input logic [2:0] a, input int stall_idx,
                            input int stall_len, input int restart_idx, input int rst_rise);
        int  i, wd;
        bit  stalled, restarted;
        use1 = u1;
        per_exp = u1 ? 2 : 4;
        exp_addr = a;
        rises = 0; per_bad = 0; sel_bad = 0; load_bad = 0; stall_bad = 0;
        done_cnt = 0; done_cyc = 0; timed_out = 0; aborted = 0;
        rdq.delete(); sinq.delete(); exp_rd.delete();
        for (int j = 0; j < BS; j++) exp_rd.push_back(chain_byte(a, j));
        @(negedge clk);
        start = 1'b1; addr = a; t_start = cyc;
        i = 0; wd = 0; stalled = 0; restarted = 0;
        while (i < BS) begin
            @(negedge clk);
            start = 1'b0;
            wd++;
            if (wd > 5000) begin
                timed_out = 1;
                break;
            end
            if (rst_rise >= 0 && rises == rst_rise && !sclk_m && busy_m) begin
                rst = 1'b1;
                @(negedge clk);
                post_ssel = ssel_m; post_sclk = sclk_m; post_busy = busy_m;
                rst = 1'b0;
                aborted = 1;
                break;
            end
            if (i == restart_idx && !restarted) begin
                start = 1'b1; addr = 3'd2; restarted = 1;
            end
            if (i == stall_idx && !stalled && wr_ready_m) begin
                wr_valid = 1'b0;
                stalling = 1'b1;
                repeat (stall_len) @(negedge clk);
                stalling = 1'b0;
                stalled = 1;
            end
            wr_data = wbytes[i];
            wr_valid = 1'b1;
            if (wr_ready_m) i++;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        start = 1'b0;
        if (!aborted && !timed_out) begin
            while (done_cnt == 0 && wd < 5000) begin
                @(negedge clk);
                wd++;
            end
            if (done_cnt == 0) timed_out = 1;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rises = 0;
        repeat (10) @(negedge clk);
        total++;
        if ({busy0, done0, wr_ready0, rd_valid0, sclk0, sin0, ssel0} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000000", {busy0, done0, wr_ready0, rd_valid0, sclk0, sin0, ssel0});
        end
        total++;
        if ({saddr0, rd_data0} !== 11'b0) begin
            bad++;
            $display("FAIL reset_data: saddr=%0d rd_data=%h want 0/00", saddr0, rd_data0);
        end
        total++;
        if ({busy1, wr_ready1, sclk1, ssel1} !== 4'b0) begin
            bad++;
            $display("FAIL reset_div1: got %b want 0000", {busy1, wr_ready1, sclk1, ssel1});
        end
        total++;
        if (rises !== 0) begin
            bad++;
            $display("FAIL reset_sclk_idle: rises=%0d want 0", rises);
        end
    endtask

    task automatic check_xfer(input string nm, input logic [2:0] a, input int exp_len);
        int e;
        total++;
        if (timed_out !== 1'b0) begin
            bad++;
            $display("FAIL %s_timeout: done not seen", nm);
        end
        total++;
        if (rises !== BS * BW) begin
            bad++;
            $display("FAIL %s_rises: got %0d want %0d", nm, rises, BS * BW);
        end
        total++;
        if (per_bad !== 0) begin
            bad++;
            $display("FAIL %s_period: %0d periods not %0d cycles", nm, per_bad, per_exp);
        end
        total++;
        if (sel_bad !== 0 || load_bad !== 0) begin
            bad++;
            $display("FAIL %s_scan_if: sel_bad=%0d load_bad=%0d want 0/0", nm, sel_bad, load_bad);
        end
        total++;
        if (done_cnt !== 1 || done_cyc - t_start !== exp_len) begin
            bad++;
            $display("FAIL %s_done: count=%0d at %0d want 1 at %0d", nm, done_cnt, done_cyc - t_start, exp_len);
        end
        total++;
        if (rdq.size() !== BS) begin
            bad++;
            $display("FAIL %s_rd_count: got %0d want %0d", nm, rdq.size(), BS);
        end else begin
            e = 0;
            for (int k = 0; k < BS; k++) if (rdq[k] !== exp_rd[k]) e++;
            if (e != 0) begin
                bad++;
                $display("FAIL %s_readback: %0d bytes wrong, first got %h want %h", nm, e, rdq[0], exp_rd[0]);
            end
        end
        total++;
        e = 0;
        for (int k = 0; k < BS; k++) if (chain_byte(a, k) !== wbytes[k]) e++;
        if (e != 0) begin
            bad++;
            $display("FAIL %s_contents: %0d bytes wrong, entry%0d got %h want %h", nm, e, BS - 1, chain_byte(a, 0), wbytes[0]);
        end
        total++;
        if (saddr_m !== a || ssel_m !== 1'b0 || busy_m !== 1'b0) begin
            bad++;
            $display("FAIL %s_after: saddr=%0d ssel=%b busy=%b want %0d/0/0", nm, saddr_m, ssel_m, busy_m, a);
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k < BS; k++) wbytes[k] = 8'(k);
        for (int k = 0; k < BS; k++)
            for (int b = 0; b < BW; b++) chain[5][k*BW+b] = 1'(8'(8'hA0 + k) >> (BW - 1 - b));
        run_xfer(0, 3'd5, -1, 0, -1, -1);
        for (int k = 0; k < BS; k++) begin
            total++;
            if (rdq.size() > k && rdq[k] !== 8'(8'hA0 + k)) begin
                bad++;
                $display("FAIL basic_rd%0d: got %h want %h", k, rdq[k], 8'(8'hA0 + k));
            end
        end
        check_xfer("basic", 3'd5, BS * (1 + BW * 4) + 1);
    endtask

    task automatic test_stall();
        logic [2:0] a;
        a = 3'($urandom_range(0, 7));
        for (int k = 0; k < BS; k++) wbytes[k] = 8'($urandom);
        run_xfer(0, a, 3, 50, -1, -1);
        total++;
        if (stall_bad !== 0) begin
            bad++;
            $display("FAIL stall_quiet: %0d stall cycles with sclk high or ssel low", stall_bad);
        end
        check_xfer("stall", a, BS * (1 + BW * 4) + 1 + 50);
    endtask

    task automatic test_restart_ignored();
        for (int k = 0; k < BS; k++) wbytes[k] = 8'($urandom);
        run_xfer(0, 3'd5, -1, 0, 10, -1);
        check_xfer("restart", 3'd5, BS * (1 + BW * 4) + 1);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < BS; k++) wbytes[k] = 8'($urandom);
        run_xfer(0, 3'd5, -1, 0, -1, 7 * BW + 3);
        total++;
        if (aborted !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_reached: reset point not reached");
        end
        total++;
        if ({post_ssel, post_sclk, post_busy} !== 3'b000) begin
            bad++;
            $display("FAIL rstmid_outputs: ssel/sclk/busy=%b want 000", {post_ssel, post_sclk, post_busy});
        end
        repeat (20) @(negedge clk);
        total++;
        if (done_cnt !== 0 || rdq.size() !== 7) begin
            bad++;
            $display("FAIL rstmid_pulses: done=%0d rd_bytes=%0d want 0/7", done_cnt, rdq.size());
        end
        for (int k = 0; k < BS; k++) wbytes[k] = 8'($urandom);
        run_xfer(0, 3'd3, -1, 0, -1, -1);
        check_xfer("fresh", 3'd3, BS * (1 + BW * 4) + 1);
    endtask

    task automatic test_clk_div1();
        logic [2:0]  a;
        logic [15:0] first16;
        a = 3'($urandom_range(0, 7));
        wbytes[0] = 8'h80;
        wbytes[1] = 8'h01;
        for (int k = 2; k < BS; k++) wbytes[k] = 8'hFF;
        run_xfer(1, a, -1, 0, -1, -1);
        first16 = '0;
        for (int k = 0; k < 16 && k < sinq.size(); k++) first16 = {first16[14:0], sinq[k]};
        total++;
        if (first16 !== 16'h8001) begin
            bad++;
            $display("FAIL div1_sin_order: got %h want 8001", first16);
        end
        check_xfer("div1", a, BS * (1 + BW * 2) + 1);
        use1 = 1'b0;
    endtask

    initial begin
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < BS * BW; k++) chain[b].push_back(1'($urandom));
        test_reset();
        test_basic();
        test_stall();
        test_restart_ignored();
        test_reset_mid();
        test_clk_div1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_loader.md
Name: scan_loader

Overview:
- Serial scan-chain master that drives the pattern-buffer scan interface: sclk, sin, ssel, saddr out; sout back in.
- Takes a byte stream from the host/config side through a valid/ready handshake.
- Shifts one whole pattern buffer (buffer_size x buffer_width bits) into the selected buffer.
- Captures the bits returned on sout at the same time and presents them as a readback byte stream, so software can read and write a buffer in one pass.

Parameters:
- buffer_size, 22: bytes per pattern buffer (bytes per transfer).
- buffer_width, 8: bits per byte.
- clk_div, 2: sclk half-period in clk cycles; must be >= 1.

Ports:
- clk  in  1: system clock.
- rst  in  1: synchronous, active-high reset.
- start  in  1: request a transfer; sampled only in IDLE.
- addr  in  3: target buffer index; latched on an accepted start.
- busy  out  1: high from the cycle after start is accepted until done.
- done  out  1: one-cycle pulse at the end of a transfer.
- wr_data  in  buffer_width: next byte to shift out.
- wr_valid  in  1: wr_data is valid.
- wr_ready  out  1: block can accept a byte this cycle.
- rd_data  out  buffer_width: byte captured from sout.
- rd_valid  out  1: one-cycle pulse; rd_data is valid.
- sclk  out  1: scan clock to the buffers.
- sin  out  1: serial data to the buffers.
- sout  in  1: serial data from the buffers; tri-stated when ssel is low, so it is ignored then.
- ssel  out  1: scan select.
- saddr  out  3: scan buffer address.

Behaviour:
- Reset values: busy, done, wr_ready, rd_valid, sclk, sin, ssel = 0; saddr = 0; rd_data = 0.
- Reset mid-transfer takes effect on the next clk edge and abandons the transfer. No done pulse, no partial rd_valid.
- FSM states: IDLE, LOAD, SHIFT, FIN.
- IDLE:
  - start=1 at cycle T: latch addr into saddr; byte counter = 0.
  - At T+1: busy=1, ssel=1, state LOAD.
  - start while busy is ignored (not queued).
- LOAD:
  - wr_ready=1 and sclk held low.
  - On wr_valid&&wr_ready: load wr_data into the shift register, set bit counter = 0, go to SHIFT.
  - A stall (wr_valid=0) holds state indefinitely. ssel stays high and sclk stays low, so the chain is not disturbed.
- SHIFT: each bit period is 2*clk_div cycles.
  - sclk is low for the first clk_div cycles and high for the second clk_div cycles.
  - sin carries the current MSB for the whole period.
  - sout is sampled in the last low-phase cycle, just before sclk rises, and shifted into the capture register LSB-first. The first bit received ends up as the capture byte's MSB.
  - After buffer_width periods, sclk returns low.
  - The capture byte goes to rd_data with rd_valid=1 for exactly one cycle: the first cycle after the final period.
  - Byte counter increments. If it is < buffer_size, go to LOAD; otherwise go to FIN.
- FIN:
  - ssel=0, busy=0, done=1 for one cycle, then IDLE.
  - saddr holds its value until the next accepted start.
- Ordering:
  - Bytes are shifted MSB-first, in the order supplied.
  - The first byte supplied lands in buffer entry buffer_size-1.
  - Readback byte k is the entry that previously occupied the chain position emptied by write byte k, i.e. the old buffer contents in the same order.
- sin is 0 whenever not in SHIFT.
- wr_ready is 0 outside LOAD.
- Zero-stall transfer length is buffer_size*(1 + buffer_width*2*clk_div) cycles from the first LOAD to FIN. With defaults this is 22*33 = 726 cycles.
- Full transfer: 176 sclk rising edges, no more and no fewer.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0; sclk never toggles; wr_ready=0.
- start with addr=5, then 22 bytes 0x00..0x15 with wr_valid held high; buffer model preloaded 0xA0..0xB5 -> saddr=5 and ssel=1 for the whole transfer; 176 sclk rises; each sclk period = 4 cycles; buffer ends with entry21=0x00..entry0=0x15; rd_data sequence is 0xA0..0xB5 (in chain order); done pulses once at cycle 727 after start.
- Drop wr_valid for 50 cycles before byte 3 -> sclk stays low and ssel stays high during the stall; final buffer contents identical to the no-stall run; total time +50 cycles.
- Assert start again at byte 10 with addr=2 -> ignored; saddr stays 5; exactly one done.
- Assert rst during the 4th bit of byte 7 -> the next cycle shows ssel=0, sclk=0, busy=0; no done or rd_valid pulse; a fresh transfer then completes normally.
- clk_div=1: send pattern 0x80, 0x01, then 20 bytes of 0xFF -> sclk period = 2 cycles; sin shows the MSB first; total transfer is 22*17 = 374 cycles.
